frame_fill_scheduler: RTL and testbench

Sequences the pixel BRAM write port for one rendered frame. First it clears the whole frame buffer to a background colour, then accepts projected 2D triangles one at a time over a valid/ready handshake. For each triangle it drives a full raster sweep into an external `triangle_2d_fill` unit and turns the fill unit's `is_within` results into pixel writes. It sits between the 3D→2D projection stage and `pixel_bram` port A, replacing the free-running hcount/vcount sweep.

---
 rtl/frame_fill_scheduler.sv | 271 +++++++++++++++++++++++++++
 tb/tb_frame_fill_scheduler.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fill_scheduler.sv
// frame_fill_scheduler: clears the pixel buffer, then rasterises
// triangles through an external fill unit into BRAM port A.
module frame_fill_scheduler #(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 384,
  parameter int COORD_BITS   = 16,
  parameter int ADDR_BITS    = 18,
  parameter int COLOR_WIDTH  = 16,
  parameter int TRI_WIDTH    = 96,
  parameter int FILL_LATENCY = 3,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   tri_valid,
  output logic                   tri_ready,
  input  logic [TRI_WIDTH-1:0]   tri_data,
  input  logic [COLOR_WIDTH-1:0] tri_color,
  input  logic                   tri_last,
  output logic [TRI_WIDTH-1:0]   fill_tri,
  output logic                   fill_valid,
  output logic [COORD_BITS-1:0]  fill_hcount,
  output logic [COORD_BITS-1:0]  fill_vcount,
  input  logic                   fill_is_within,
  output logic                   pix_we,
  output logic [ADDR_BITS-1:0]   pix_addr,
  output logic [COLOR_WIDTH-1:0] pix_data,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int NPIX = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int DW   = $clog2(FILL_LATENCY + 2);
  localparam int LT   = FILL_LATENCY - 1;

  localparam logic [COORD_BITS-1:0] H_LAST =
    COORD_BITS'(FRAME_WIDTH - 1);
  localparam logic [COORD_BITS-1:0] V_LAST =
    COORD_BITS'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] A_LAST =
    ADDR_BITS'(NPIX - 1);
  localparam logic [DW-1:0] D_LAST =
    DW'(FILL_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_TRI,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [COORD_BITS-1:0]  h_q, h_d, h_nx;
  logic [COORD_BITS-1:0]  v_q, v_d, v_nx;
  logic [ADDR_BITS-1:0]   addr_q, addr_d, addr_nx;
  logic [DW-1:0]          drain_q, drain_d;
  logic [TRI_WIDTH-1:0]   fill_tri_q, fill_tri_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  logic                   last_q, last_d;

  logic                   fill_valid_q, fill_valid_d;
  logic [COORD_BITS-1:0]  fill_h_q, fill_h_d;
  logic [COORD_BITS-1:0]  fill_v_q, fill_v_d;
  logic [ADDR_BITS-1:0]   faddr_q, faddr_d;

  logic [FILL_LATENCY-1:0] pv_q, pv_d;
  logic [ADDR_BITS-1:0]    pa_q [FILL_LATENCY];
  logic [ADDR_BITS-1:0]    pa_d [FILL_LATENCY];

  logic                   pix_we_q, pix_we_d;
  logic [ADDR_BITS-1:0]   pix_addr_q, pix_addr_d;
  logic [COLOR_WIDTH-1:0] pix_data_q, pix_data_d;
  logic                   done_q, done_d;

  logic clr_we;
  logic sweep_end;

  assign tri_ready   = (state_q == S_WAIT_TRI);
  assign busy        = (state_q != S_IDLE);
  assign fill_tri    = fill_tri_q;
  assign fill_valid  = fill_valid_q;
  assign fill_hcount = fill_h_q;
  assign fill_vcount = fill_v_q;
  assign pix_we      = pix_we_q;
  assign pix_addr    = pix_addr_q;
  assign pix_data    = pix_data_q;
  assign frame_done  = done_q;

  // raster step: h wraps at row end, address runs alongside
  always_comb begin
    h_nx    = h_q + 1'b1;
    v_nx    = v_q;
    addr_nx = addr_q + 1'b1;
    if (h_q == H_LAST) begin
      h_nx = '0;
      v_nx = v_q + 1'b1;
    end
  end

  assign sweep_end = (h_q == H_LAST) && (v_q == V_LAST);

  // next-state, counters, triangle latch and sweep outputs
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    fill_tri_d   = fill_tri_q;
    color_d      = color_q;
    last_d       = last_q;
    fill_valid_d = 1'b0;
    fill_h_d     = fill_h_q;
    fill_v_d     = fill_v_q;
    faddr_d      = faddr_q;
    clr_we       = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          h_d     = '0;
          v_d     = '0;
          addr_d  = '0;
        end
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        h_d    = h_nx;
        v_d    = v_nx;
        addr_d = addr_nx;
        if (addr_q == A_LAST) begin
          state_d = S_WAIT_TRI;
        end
      end
      S_WAIT_TRI: begin
        if (tri_valid) begin
          state_d    = S_SWEEP;
          fill_tri_d = tri_data;
          color_d    = tri_color;
          last_d     = tri_last;
          h_d        = '0;
          v_d        = '0;
          addr_d     = '0;
        end
      end
      S_SWEEP: begin
        fill_valid_d = 1'b1;
        fill_h_d     = h_q;
        fill_v_d     = v_q;
        faddr_d      = addr_q;
        h_d          = h_nx;
        v_d          = v_nx;
        addr_d       = addr_nx;
        if (sweep_end) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == D_LAST) begin
          if (last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_TRI;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d      = S_IDLE;
      fill_tri_d   = fill_tri_q;
      color_d      = color_q;
      last_d       = last_q;
      fill_valid_d = 1'b0;
      clr_we       = 1'b0;
      done_d       = 1'b0;
    end
  end

  // result pipe aligned to fill unit latency, then write port
  always_comb begin
    for (int i = 0; i < FILL_LATENCY; i++) begin
      if (i == 0) begin
        pv_d[i] = fill_valid_q;
        pa_d[i] = faddr_q;
      end else begin
        pv_d[i] = pv_q[i-1];
        pa_d[i] = pa_q[i-1];
      end
    end
    pix_we_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    if (clr_we) begin
      pix_we_d   = 1'b1;
      pix_addr_d = addr_q;
      pix_data_d = CLEAR_COLOR;
    end else if (pv_q[LT] && fill_is_within) begin
      pix_we_d   = 1'b1;
      pix_addr_d = pa_q[LT];
      pix_data_d = color_q;
    end
    if (abort) begin
      pv_d     = '0;
      pix_we_d = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      addr_q       <= '0;
      drain_q      <= '0;
      fill_tri_q   <= '0;
      color_q      <= '0;
      last_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_h_q     <= '0;
      fill_v_q     <= '0;
      faddr_q      <= '0;
      pv_q         <= '0;
      for (int i = 0; i < FILL_LATENCY; i++) begin
        pa_q[i] <= '0;
      end
      pix_we_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      addr_q       <= addr_d;
      drain_q      <= drain_d;
      fill_tri_q   <= fill_tri_d;
      color_q      <= color_d;
      last_q       <= last_d;
      fill_valid_q <= fill_valid_d;
      fill_h_q     <= fill_h_d;
      fill_v_q     <= fill_v_d;
      faddr_q      <= faddr_d;
      pv_q         <= pv_d;
      for (int i = 0; i < FILL_LATENCY; i++) begin
        pa_q[i] <= pa_d[i];
      end
      pix_we_q     <= pix_we_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_frame_fill_scheduler.sv
// tb_frame_fill_scheduler: directed bench with a 3-cycle fill
// unit model and a write log captured just after each edge.
module tb_frame_fill_scheduler;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int L  = 3;
  localparam int TW = 96;
  localparam int CW = 16;
  localparam int AB = 18;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          tri_valid;
  logic          tri_ready;
  logic [TW-1:0] tri_data;
  logic [CW-1:0] tri_color;
  logic          tri_last;
  logic [TW-1:0] fill_tri;
  logic          fill_valid;
  logic [CB-1:0] fill_hcount;
  logic [CB-1:0] fill_vcount;
  logic          fill_is_within;
  logic          pix_we;
  logic [AB-1:0] pix_addr;
  logic [CW-1:0] pix_data;
  logic          busy;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  frame_fill_scheduler #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .COORD_BITS  (CB),
    .ADDR_BITS   (AB),
    .COLOR_WIDTH (CW),
    .TRI_WIDTH   (TW),
    .FILL_LATENCY(L),
    .CLEAR_COLOR (16'h0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .tri_valid     (tri_valid),
    .tri_ready     (tri_ready),
    .tri_data      (tri_data),
    .tri_color     (tri_color),
    .tri_last      (tri_last),
    .fill_tri      (fill_tri),
    .fill_valid    (fill_valid),
    .fill_hcount   (fill_hcount),
    .fill_vcount   (fill_vcount),
    .fill_is_within(fill_is_within),
    .pix_we        (pix_we),
    .pix_addr      (pix_addr),
    .pix_data      (pix_data),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // fill unit model: result L cycles after the coordinate
  logic          mode_all = 1'b0;
  logic          mv1 = 1'b0, mv2 = 1'b0, mv3 = 1'b0;
  logic [CB-1:0] mh1 = '0, mh2 = '0, mh3 = '0;

  always @(posedge clk) begin
    mv1 <= fill_valid;
    mh1 <= fill_hcount;
    mv2 <= mv1;
    mh2 <= mh1;
    mv3 <= mv2;
    mh3 <= mh2;
  end

  assign fill_is_within = mv3 && (mode_all || (mh3 < CB'(4)));

  // write and frame_done log, sampled 1 time unit after each edge
  logic [AB-1:0] la[$];
  logic [CW-1:0] ld[$];
  int            lc[$];
  int            done_cnt = 0;
  int            done_cyc = 0;

  always @(posedge clk) begin
    #1;
    if (pix_we === 1'b1) begin
      la.push_back(pix_addr);
      ld.push_back(pix_data);
      lc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    la.delete();
    ld.delete();
    lc.delete();
  endtask

  task automatic run_clear(output int e, output int r);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = cyc;
    r = -1;
    for (int i = 0; i < 100 && r < 0; i++) begin
      if (tri_ready) r = cyc;
      else @(negedge clk);
    end
  endtask

  task automatic wait_done(input int d0, output int ok);
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk);
      if (done_cnt != d0) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    tri_valid = 1'b0;
    tri_data  = '0;
    tri_color = '0;
    tri_last  = 1'b0;
    #23;
    total++;
    if ({tri_ready, fill_valid, pix_we, busy, frame_done}
        !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=00000",
        {tri_ready, fill_valid, pix_we, busy, frame_done});
    end
    total++;
    if ({fill_hcount, fill_vcount, pix_addr, pix_data} !== '0)
    begin
      bad++;
      $display("FAIL reset_data h=%0d v=%0d a=%0d d=%h want 0",
        fill_hcount, fill_vcount, pix_addr, pix_data);
    end
    total++;
    if (fill_tri !== '0) begin
      bad++;
      $display("FAIL reset_tri got=%h want=0", fill_tri);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clear();
    int e, r, err;
    clear_log();
    run_clear(e, r);
    total++;
    if (r !== e + 32) begin
      bad++;
      $display("FAIL clear_ready got=%0d want=%0d", r, e + 32);
    end
    total++;
    if (la.size() !== 32) begin
      bad++;
      $display("FAIL clear_count got=%0d want=32", la.size());
    end
    err = 0;
    for (int i = 0; i < la.size(); i++) begin
      if (la[i] !== AB'(i) || ld[i] !== 16'h0000 ||
          lc[i] !== e + 1 + i) err++;
    end
    total++;
    if (err != 0) begin
      bad++;
      $display("FAIL clear_seq bad_entries=%0d want=0", err);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL clear_busy got=%b want=1", busy);
    end
  endtask

  task automatic test_one_tri();
    int t, ok, d0, err;
    logic [TW-1:0] td;
    td = 96'h1111_2222_3333_4444_5555_6666;
    mode_all = 1'b0;
    clear_log();
    d0 = done_cnt;
    tri_valid = 1'b1;
    tri_data  = td;
    tri_color = 16'h0F0F;
    tri_last  = 1'b1;
    @(negedge clk);
    t = cyc;
    tri_valid = 1'b0;
    total++;
    if (fill_tri !== td) begin
      bad++;
      $display("FAIL one_filltri got=%h want=%h", fill_tri, td);
    end
    wait_done(d0, ok);
    total++;
    if (ok == 0 || done_cyc !== t + 36) begin
      bad++;
      $display("FAIL one_done got=%0d want=%0d", done_cyc, t + 36);
    end
    total++;
    if (la.size() !== 16) begin
      bad++;
      $display("FAIL one_count got=%0d want=16", la.size());
    end
    err = 0;
    for (int k = 0; k < la.size() && k < 16; k++) begin
      if (la[k] !== AB'((k / 4) * 8 + (k % 4)) ||
          ld[k] !== 16'h0F0F) err++;
    end
    total++;
    if (err != 0) begin
      bad++;
      $display("FAIL one_addr bad_entries=%0d want=0", err);
    end
    total++;
    if (la.size() > 0 && lc[0] !== t + 5) begin
      bad++;
      $display("FAIL one_first got=%0d want=%0d", lc[0], t + 5);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0 ||
        done_cnt !== d0 + 1) begin
      bad++;
      $display("FAIL one_idle busy=%b fd=%b cnt=%0d want 0 0 %0d",
        busy, frame_done, done_cnt, d0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int e, r, t1, t2, ok, d0, na, nb, seen_b, order_err, tri_err;
    logic [TW-1:0] ta, tb;
    ta = 96'hAAAA_0000_AAAA_0000_AAAA_0001;
    tb = 96'hBBBB_0000_BBBB_0000_BBBB_0002;
    mode_all = 1'b0;
    run_clear(e, r);
    clear_log();
    d0 = done_cnt;
    tri_valid = 1'b1;
    tri_data  = ta;
    tri_color = 16'hAAAA;
    tri_last  = 1'b0;
    @(negedge clk);
    t1 = cyc;
    tri_data  = tb;
    tri_color = 16'hBBBB;
    tri_last  = 1'b1;
    t2 = -1;
    tri_err = 0;
    for (int i = 0; i < 100 && t2 < 0; i++) begin
      if (fill_tri !== ta) tri_err++;
      if (tri_ready) t2 = cyc + 1;
      else @(negedge clk);
    end
    @(negedge clk);
    tri_valid = 1'b0;
    total++;
    if (tri_err != 0 || fill_tri !== tb) begin
      bad++;
      $display("FAIL b2b_filltri early_changes=%0d got=%h want=%h",
        tri_err, fill_tri, tb);
    end
    total++;
    if (t2 - t1 !== 37) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=37", t2 - t1);
    end
    wait_done(d0, ok);
    total++;
    if (ok == 0) begin
      bad++;
      $display("FAIL b2b_done got=timeout want=pulse");
    end
    na = 0;
    nb = 0;
    seen_b = 0;
    order_err = 0;
    for (int i = 0; i < ld.size(); i++) begin
      if (ld[i] === 16'hAAAA) begin
        na++;
        if (seen_b != 0) order_err++;
      end else if (ld[i] === 16'hBBBB) begin
        nb++;
        seen_b = 1;
      end
    end
    total++;
    if (na !== 16 || nb !== 16 || order_err != 0) begin
      bad++;
      $display("FAIL b2b_writes a=%0d b=%0d late_a=%0d want 16 16 0",
        na, nb, order_err);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int e, r, ax, d0, err, we_err;
    mode_all = 1'b0;
    run_clear(e, r);
    clear_log();
    d0 = done_cnt;
    tri_valid = 1'b1;
    tri_data  = 96'h5;
    tri_color = 16'h5555;
    tri_last  = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    ax = -1;
    for (int i = 0; i < 60 && ax < 0; i++) begin
      if (fill_valid && fill_hcount == CB'(5) &&
          fill_vcount == CB'(2)) ax = cyc;
      else @(negedge clk);
    end
    total++;
    if (ax < 0) begin
      bad++;
      $display("FAIL abort_reach got=timeout want=coord(5,2)");
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (pix_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_next we=%b busy=%b want 0 0",
        pix_we, busy);
    end
    we_err = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pix_we !== 1'b0) we_err++;
    end
    err = 0;
    for (int i = 0; i < la.size(); i++) begin
      if (lc[i] > ax || la[i] >= AB'(21)) err++;
    end
    total++;
    if (la.size() !== 10 || err != 0 || we_err != 0) begin
      bad++;
      $display("FAIL abort_writes n=%0d late=%0d we=%0d want 10 0 0",
        la.size(), err, we_err);
    end
    total++;
    if (done_cnt !== d0) begin
      bad++;
      $display("FAIL abort_nodone got=%0d want=%0d", done_cnt, d0);
    end
    clear_log();
    run_clear(e, r);
    err = 0;
    for (int i = 0; i < la.size(); i++) begin
      if (la[i] !== AB'(i) || ld[i] !== 16'h0000) err++;
    end
    total++;
    if (la.size() !== 32 || err != 0 || r !== e + 32) begin
      bad++;
      $display("FAIL abort_reclear n=%0d bad=%0d rdy=%0d want 32 0 %0d",
        la.size(), err, r, e + 32);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start_held();
    int r, ok, d0, nclr, ncol, mid;
    @(negedge clk);
    rst_n     = 1'b0;
    start     = 1'b1;
    tri_valid = 1'b1;
    tri_data  = 96'hC0C0_C0C0;
    tri_color = 16'h00FF;
    tri_last  = 1'b1;
    mode_all  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    d0 = done_cnt;
    r = -1;
    for (int i = 0; i < 100 && r < 0; i++) begin
      @(negedge clk);
      if (tri_ready) r = cyc;
    end
    total++;
    if (r < 0 || fill_tri !== '0 || la.size() !== 32) begin
      bad++;
      $display("FAIL held_wait rdy=%0d tri=%h n=%0d want tri=0 n=32",
        r, fill_tri, la.size());
    end
    @(negedge clk);
    tri_valid = 1'b0;
    wait_done(d0, ok);
    nclr = 0;
    ncol = 0;
    for (int i = 0; i < ld.size(); i++) begin
      if (lc[i] <= done_cyc && ld[i] === 16'h0000) nclr++;
      if (ld[i] === 16'h00FF) ncol++;
    end
    total++;
    if (ok == 0 || nclr !== 32 || ncol !== 32) begin
      bad++;
      $display("FAIL held_frame done=%0d clr=%0d col=%0d want 1 32 32",
        ok, nclr, ncol);
    end
    mid = 0;
    for (int i = 0; i < 10 && mid == 0; i++) begin
      @(negedge clk);
      if (busy && pix_we) mid = 1;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (mid == 0 || {pix_we, busy, fill_valid, tri_ready,
        frame_done} !== 5'b0 || pix_addr !== '0 ||
        fill_tri !== '0) begin
      bad++;
      $display("FAIL held_rst mid=%0d ctl=%b a=%0d want 1 00000 0",
        mid, {pix_we, busy, fill_valid, tri_ready, frame_done},
        pix_addr);
    end
    start     = 1'b0;
    tri_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_one_tri();
    test_back_to_back();
    test_abort();
    test_start_held();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
